// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared definitions for the system-controller receive path.
// Holds the frame opcodes, the parser state encoding, the register-file
// addresses that receive ALU operands A and B, and the timeout counter width.
package sys_ctrl_pkg;

   localparam logic [7:0] OPC_WR     = 8'hAA;
   localparam logic [7:0] OPC_RD     = 8'hBB;
   localparam logic [7:0] OPC_ALU_OP = 8'hCC;
   localparam logic [7:0] OPC_ALU_NO = 8'hDD;

   localparam int unsigned ALU_OPA_ADDR = 0;
   localparam int unsigned ALU_OPB_ADDR = 1;

   localparam int unsigned TO_CNT_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_OP_A,
      ST_OP_B,
      ST_ALU_FUN
   } state_t;

   // States in which the ALU clock must already be running.
   function automatic logic is_alu_state(state_t s);
      return (s == ST_OP_A) || (s == ST_OP_B) || (s == ST_ALU_FUN);
   endfunction

endpackage

// File: rtl/sys_ctrl_rx_if.sv
// sys_ctrl_rx_if: bundle between the bus synchronizer, the command decoder
// and the register file / ALU.
//   RX_P_DATA, RX_D_VLD      : synchronized byte and its one-cycle valid
//   RF_WrEn, RF_RdEn         : register-file write / read strobes
//   RF_Address, RF_WrData    : register-file address and write data
//   ALU_EN, ALU_FUN          : ALU execute strobe and function code
//   CLK_GATE_EN              : ALU clock-gate enable
//   FRAME_ABORT              : pulse when a partial frame times out
// master: byte source side; slave: command decoder side.
interface sys_ctrl_rx_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] RX_P_DATA;
   logic                  RX_D_VLD;
   logic                  RF_WrEn;
   logic                  RF_RdEn;
   logic [ADDR_WIDTH-1:0] RF_Address;
   logic [DATA_WIDTH-1:0] RF_WrData;
   logic                  ALU_EN;
   logic [3:0]            ALU_FUN;
   logic                  CLK_GATE_EN;
   logic                  FRAME_ABORT;

   modport master (
      output RX_P_DATA, RX_D_VLD,
      input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
      input  ALU_EN, ALU_FUN, CLK_GATE_EN, FRAME_ABORT
   );

   modport slave (
      input  RX_P_DATA, RX_D_VLD,
      output RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
      output ALU_EN, ALU_FUN, CLK_GATE_EN, FRAME_ABORT
   );
endinterface

// File: rtl/sys_ctrl_timeout.sv
// sys_ctrl_timeout: inter-byte inactivity counter.
//   CLK, RST : clock, asynchronous active-high reset
//   clr      : clear counter (has priority over en)
//   en       : count this cycle
//   tc       : combinational terminal count; high in the cycle whose count
//              step brings the counter to TIMEOUT, so the caller can act on
//              the same edge
module sys_ctrl_timeout
   import sys_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [TO_CNT_WIDTH-1:0] cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = en && !clr && (cnt == TO_CNT_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/sys_ctrl_rx.sv
// sys_ctrl_rx: command-frame parser of the system controller.
// Decodes AA/BB/CC/DD frames from the synchronized byte stream and issues
// registered one-cycle register-file and ALU strobes one cycle after the
// byte that completes each step. A partial frame that goes quiet for
// TIMEOUT cycles is dropped with a FRAME_ABORT pulse.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : sys_ctrl_rx_if slave (byte input, RF/ALU outputs)
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_IDLE     | waiting for an opcode byte
// ST_WR_ADDR  | write frame, next byte is the address
// ST_WR_DATA  | write frame, next byte is the data
// ST_RD_ADDR  | read frame, next byte is the address
// ST_OP_A     | ALU frame, next byte is operand A (-> RF addr 0)
// ST_OP_B     | ALU frame, next byte is operand B (-> RF addr 1)
// ST_ALU_FUN  | next byte carries the ALU function code
module sys_ctrl_rx
   import sys_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic         CLK,
   input  logic         RST,
   sys_ctrl_rx_if.slave bus
);

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] rx_byte;
   logic                  rx_vld;
   logic                  to_tc;

   logic [ADDR_WIDTH-1:0] addr_lat, addr_lat_d;
   logic [ADDR_WIDTH-1:0] rf_addr, rf_addr_d;
   logic [DATA_WIDTH-1:0] rf_wdata, rf_wdata_d;
   logic [3:0]            alu_fun, alu_fun_d;
   logic                  wr_en, wr_en_d;
   logic                  rd_en, rd_en_d;
   logic                  alu_en, alu_en_d;
   logic                  gate, gate_d;
   logic                  abort, abort_d;

   assign rx_byte = bus.RX_P_DATA;
   assign rx_vld  = bus.RX_D_VLD;

   // Counter only runs mid-frame; any byte restarts the idle window.
   sys_ctrl_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .CLK (CLK),
      .RST (RST),
      .clr (rx_vld || (state == ST_IDLE)),
      .en  (state != ST_IDLE),
      .tc  (to_tc)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= ST_IDLE;
         addr_lat <= '0;
         rf_addr  <= '0;
         rf_wdata <= '0;
         alu_fun  <= '0;
         wr_en    <= 1'b0;
         rd_en    <= 1'b0;
         alu_en   <= 1'b0;
         gate     <= 1'b0;
         abort    <= 1'b0;
      end else begin
         state    <= state_nxt;
         addr_lat <= addr_lat_d;
         rf_addr  <= rf_addr_d;
         rf_wdata <= rf_wdata_d;
         alu_fun  <= alu_fun_d;
         wr_en    <= wr_en_d;
         rd_en    <= rd_en_d;
         alu_en   <= alu_en_d;
         gate     <= gate_d;
         abort    <= abort_d;
      end
   end

   // A byte arriving on the terminal-count cycle takes priority over the abort.
   always_comb begin
      state_nxt = state;
      if (rx_vld) begin
         case (state)
            ST_IDLE: begin
               if (rx_byte == DATA_WIDTH'(OPC_WR))
                  state_nxt = ST_WR_ADDR;
               else if (rx_byte == DATA_WIDTH'(OPC_RD))
                  state_nxt = ST_RD_ADDR;
               else if (rx_byte == DATA_WIDTH'(OPC_ALU_OP))
                  state_nxt = ST_OP_A;
               else if (rx_byte == DATA_WIDTH'(OPC_ALU_NO))
                  state_nxt = ST_ALU_FUN;
               else
                  state_nxt = ST_IDLE;
            end
            ST_WR_ADDR: state_nxt = ST_WR_DATA;
            ST_WR_DATA: state_nxt = ST_IDLE;
            ST_RD_ADDR: state_nxt = ST_IDLE;
            ST_OP_A:    state_nxt = ST_OP_B;
            ST_OP_B:    state_nxt = ST_ALU_FUN;
            ST_ALU_FUN: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
         endcase
      end else if (to_tc) begin
         state_nxt = ST_IDLE;
      end
   end

   // Next values of the output registers; address/data/function hold by default.
   always_comb begin
      addr_lat_d = addr_lat;
      rf_addr_d  = rf_addr;
      rf_wdata_d = rf_wdata;
      alu_fun_d  = alu_fun;
      wr_en_d    = 1'b0;
      rd_en_d    = 1'b0;
      alu_en_d   = 1'b0;
      abort_d    = 1'b0;
      if (rx_vld) begin
         case (state)
            ST_WR_ADDR: addr_lat_d = rx_byte[ADDR_WIDTH-1:0];
            ST_WR_DATA: begin
               wr_en_d    = 1'b1;
               rf_addr_d  = addr_lat;
               rf_wdata_d = rx_byte;
            end
            ST_RD_ADDR: begin
               rd_en_d   = 1'b1;
               rf_addr_d = rx_byte[ADDR_WIDTH-1:0];
            end
            ST_OP_A: begin
               wr_en_d    = 1'b1;
               rf_addr_d  = ADDR_WIDTH'(ALU_OPA_ADDR);
               rf_wdata_d = rx_byte;
            end
            ST_OP_B: begin
               wr_en_d    = 1'b1;
               rf_addr_d  = ADDR_WIDTH'(ALU_OPB_ADDR);
               rf_wdata_d = rx_byte;
            end
            ST_ALU_FUN: begin
               alu_en_d  = 1'b1;
               alu_fun_d = rx_byte[3:0];
            end
            default: ;
         endcase
      end else begin
         abort_d = to_tc;
      end
      // Registered gate tracks the next state, and stays on for the ALU_EN cycle.
      gate_d = is_alu_state(state_nxt) || alu_en_d;
   end

   assign bus.RF_WrEn     = wr_en;
   assign bus.RF_RdEn     = rd_en;
   assign bus.RF_Address  = rf_addr;
   assign bus.RF_WrData   = rf_wdata;
   assign bus.ALU_EN      = alu_en;
   assign bus.ALU_FUN     = alu_fun;
   assign bus.CLK_GATE_EN = gate;
   assign bus.FRAME_ABORT = abort;

endmodule

// File: tb/tb_sys_ctrl_rx.sv
module tb_sys_ctrl_rx;

   localparam logic [3:0] K_WR    = 4'b0001;
   localparam logic [3:0] K_RD    = 4'b0010;
   localparam logic [3:0] K_ALU   = 4'b0100;
   localparam logic [3:0] K_ABORT = 4'b1000;

   typedef struct {
      int         cyc;
      logic [3:0] kind;
      logic [3:0] addr;
      logic [7:0] data;
      logic [3:0] fun;
      logic       gate;
   } ev_t;

   // kind 0: all outputs zero, 1: CLK_GATE_EN == val, 3: scoreboard drained
   typedef struct {
      int    cyc;
      int    kind;
      logic  val;
      string name;
   } lvl_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   ev_t  sb[$];
   lvl_t lq[$];

   sys_ctrl_rx_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) rx ();

   sys_ctrl_rx #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (rx)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic drive(input logic [7:0] b);
      @(posedge CLK);
      #1;
      rx.RX_P_DATA = b;
      rx.RX_D_VLD  = 1'b1;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
         rx.RX_D_VLD = 1'b0;
      end
   endtask

   task automatic exp_ev(input logic [3:0] kind, input logic [3:0] addr,
                         input logic [7:0] data, input logic [3:0] fun,
                         input logic gate, input int dly);
      ev_t e;
      e.cyc = cyc + dly; e.kind = kind; e.addr = addr;
      e.data = data; e.fun = fun; e.gate = gate;
      sb.push_back(e);
   endtask

   task automatic exp_lvl(input int kind, input logic val, input string name, input int dly);
      lvl_t l;
      l.cyc = cyc + dly; l.kind = kind; l.val = val; l.name = name;
      lq.push_back(l);
   endtask

   // Monitor / scoreboard: every strobe cycle pops one expected event.
   initial begin
      ev_t        e;
      lvl_t       l;
      logic [3:0] gk;
      logic       ok;
      forever begin
         @(negedge CLK);
         gk = {rx.FRAME_ABORT, rx.ALU_EN, rx.RF_RdEn, rx.RF_WrEn};
         if (gk != 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event cyc=%0d got kind=%b addr=%h data=%h fun=%h, required no event",
                        cyc, gk, rx.RF_Address, rx.RF_WrData, rx.ALU_FUN);
            end else begin
               e  = sb.pop_front();
               ok = (cyc == e.cyc) && (gk == e.kind) && (rx.CLK_GATE_EN == e.gate);
               if ((e.kind == K_WR) || (e.kind == K_RD)) ok = ok && (rx.RF_Address == e.addr);
               if (e.kind == K_WR)  ok = ok && (rx.RF_WrData == e.data);
               if (e.kind == K_ALU) ok = ok && (rx.ALU_FUN == e.fun);
               if (!ok) begin
                  errors++;
                  $display("FAIL event got cyc=%0d kind=%b addr=%h data=%h fun=%h gate=%b, required cyc=%0d kind=%b addr=%h data=%h fun=%h gate=%b",
                           cyc, gk, rx.RF_Address, rx.RF_WrData, rx.ALU_FUN, rx.CLK_GATE_EN,
                           e.cyc, e.kind, e.addr, e.data, e.fun, e.gate);
               end
            end
         end
         while (lq.size() > 0 && lq[0].cyc <= cyc) begin
            l = lq.pop_front();
            checks++;
            case (l.kind)
               0: if ({rx.RF_WrEn, rx.RF_RdEn, rx.RF_Address, rx.RF_WrData, rx.ALU_EN,
                       rx.ALU_FUN, rx.CLK_GATE_EN, rx.FRAME_ABORT} != '0) begin
                     errors++;
                     $display("FAIL %s got wr=%b rd=%b addr=%h data=%h alu=%b fun=%h gate=%b abort=%b, required all 0",
                              l.name, rx.RF_WrEn, rx.RF_RdEn, rx.RF_Address, rx.RF_WrData,
                              rx.ALU_EN, rx.ALU_FUN, rx.CLK_GATE_EN, rx.FRAME_ABORT);
                  end
               1: if (rx.CLK_GATE_EN !== l.val) begin
                     errors++;
                     $display("FAIL %s got CLK_GATE_EN=%b, required %b", l.name, rx.CLK_GATE_EN, l.val);
                  end
               default: if (sb.size() != 0) begin
                     errors++;
                     $display("FAIL %s got %0d pending events (next at cyc %0d), required 0",
                              l.name, sb.size(), sb[0].cyc);
                  end
            endcase
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got time limit reached, required end of stimulus");
      $fatal(1, "watchdog");
   end

   initial begin
      rx.RX_P_DATA = 8'h00;
      rx.RX_D_VLD  = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      exp_lvl(0, 1'b0, "reset_outputs", 0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      gap(2);

      // Write frame
      drive(8'hAA); drive(8'h05); drive(8'h3C);
      exp_ev(K_WR, 4'h5, 8'h3C, 4'h0, 1'b0, 1);
      gap(2);

      // Read frame
      drive(8'hBB); drive(8'h07);
      exp_ev(K_RD, 4'h7, 8'h00, 4'h0, 1'b0, 1);
      gap(2);

      // ALU frame with operands, back-to-back
      drive(8'hCC);
      exp_lvl(1, 1'b1, "gate_after_cc", 1);
      drive(8'h12); exp_ev(K_WR, 4'h0, 8'h12, 4'h0, 1'b1, 1);
      drive(8'h34); exp_ev(K_WR, 4'h1, 8'h34, 4'h0, 1'b1, 1);
      drive(8'h02); exp_ev(K_ALU, 4'h0, 8'h00, 4'h2, 1'b1, 1);
      exp_lvl(1, 1'b0, "gate_after_alu", 2);
      gap(3);

      // ALU frame without operands, 2 idle cycles mid-frame (< TIMEOUT)
      drive(8'hDD);
      exp_lvl(1, 1'b1, "gate_after_dd", 1);
      gap(2);
      drive(8'h0A); exp_ev(K_ALU, 4'h0, 8'h00, 4'hA, 1'b1, 1);
      drive(8'hDD);
      drive(8'hF3); exp_ev(K_ALU, 4'h0, 8'h00, 4'h3, 1'b1, 1);
      gap(2);

      // Garbage byte then write, all consecutive
      drive(8'h55); drive(8'hAA); drive(8'h01); drive(8'hFF);
      exp_ev(K_WR, 4'h1, 8'hFF, 4'h0, 1'b0, 1);
      gap(2);

      // Truncated write frame: abort at n+TIMEOUT+1
      drive(8'hAA); drive(8'h03);
      exp_ev(K_ABORT, 4'h0, 8'h00, 4'h0, 1'b0, 5);
      gap(6);
      drive(8'hBB); drive(8'h03);
      exp_ev(K_RD, 4'h3, 8'h00, 4'h0, 1'b0, 1);
      gap(2);

      // Byte landing exactly on the terminal-count cycle
      drive(8'hAA); drive(8'h06);
      gap(3);
      drive(8'h77); exp_ev(K_WR, 4'h6, 8'h77, 4'h0, 1'b0, 1);
      gap(7);

      // Timeout from inside an ALU frame
      drive(8'hCC);
      drive(8'h44);
      exp_ev(K_WR, 4'h0, 8'h44, 4'h0, 1'b1, 1);
      exp_ev(K_ABORT, 4'h0, 8'h00, 4'h0, 1'b0, 5);
      gap(7);

      // Reset mid-frame
      drive(8'hCC);
      drive(8'h11); exp_ev(K_WR, 4'h0, 8'h11, 4'h0, 1'b1, 1);
      gap(1);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      exp_lvl(0, 1'b0, "midframe_reset", 0);
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      drive(8'hBB); drive(8'h02);
      exp_ev(K_RD, 4'h2, 8'h00, 4'h0, 1'b0, 1);
      gap(3);

      exp_lvl(3, 1'b0, "scoreboard_drained", 0);
      repeat (2) @(posedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
